// File: rtl/note_spawner_pkg.sv
// Shared types and constants for the random-mode note spawner.
package note_spawner_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] DIFF_EASY   = 2'd0;
  localparam logic [1:0] DIFF_NORMAL = 2'd1;
  localparam logic [1:0] DIFF_HARD   = 2'd2;
  localparam logic [1:0] DIFF_EXPERT = 2'd3;

  // Beat thinning: does the beat at position idx (0..3 in the bar) carry a note?
  function automatic logic beat_gate(input logic [1:0] diff, input logic [1:0] idx);
    case (diff)
      DIFF_EASY:   return (idx == 2'd0);
      DIFF_NORMAL: return ~idx[0];
      DIFF_HARD:   return (idx != 2'd3);
      DIFF_EXPERT: return 1'b1;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] col);
    return LANES'(1) << col;
  endfunction

endpackage

// File: rtl/note_spawner_if.sv
// Note hand-off channel from the spawner to the falling-note/lane engine.
// Handshake: the master holds spawn_valid/spawn_col/spawn_mask stable while
// spawn_valid=1; a transfer happens on every rising clk edge where
// spawn_valid && spawn_ready. spawn_ready may be driven independently of valid.
interface note_spawner_if;
  import note_spawner_pkg::*;

  logic              spawn_valid;
  logic              spawn_ready;
  logic [LANE_W-1:0] spawn_col;
  logic [LANES-1:0]  spawn_mask;

  modport master (output spawn_valid, output spawn_col, output spawn_mask, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_col, input spawn_mask, output spawn_ready);
endinterface

// File: rtl/note_spawner_fifo.sv
// Small synchronous FIFO for pending notes; head is read straight from storage.
module note_spawner_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; storage cleared on reset so head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/note_spawner.sv
// Random-mode note generator: beat thinning, same-lane repeat cap, note queue.
module note_spawner
  import note_spawner_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_REPEAT = 2,
  parameter int NOTE_TOTAL = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             beat_tick,
  input  logic [3:0]       random_col,
  input  logic [1:0]       difficulty,
  note_spawner_if.master   spawn,
  output logic [CNT_W-1:0] notes_spawned,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_t           fsm_state
);
  localparam int RW = $clog2(MAX_REPEAT + 1);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NOTE_TOTAL);
  localparam logic [RW-1:0]    REP_MAX = RW'(MAX_REPEAT);

  state_t              state, state_next;
  logic                gen_en, song_start;
  logic [1:0]          beat_idx;
  logic                have_last;
  logic [LANE_W-1:0]   last_col;
  logic [RW-1:0]       repeat_cnt;
  logic                song_full, gen, pop, push_ok;
  logic                same_lane, capped;
  logic [LANE_W-1:0]   cand, pick_col, fifo_head;
  logic [RW-1:0]       pick_rep;
  logic                fifo_full, fifo_empty;
  logic [1:0]          unused_col_bits;

  assign unused_col_bits = random_col[3:2];
  assign song_full       = (notes_spawned == TOTAL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; finishing the song takes priority over pause.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (song_full)  state_next = ST_DRAIN;
        else if (pause) state_next = ST_PAUSED;
      end
      ST_PAUSED: if (!pause) state_next = ST_RUN;
      ST_DRAIN:  if (fifo_empty) state_next = ST_DONE;
      ST_DONE:   if (start) state_next = ST_RUN;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State-decoded controls and status.
  always_comb begin
    gen_en     = (state == ST_RUN);
    song_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    busy       = (state == ST_RUN) || (state == ST_PAUSED) || (state == ST_DRAIN);
    done       = (state == ST_DONE);
  end

  // A note is generated on a thinned beat; it is queued if there is room
  // (a same-cycle pop frees a slot on a full queue).
  assign gen     = gen_en && beat_tick && !song_full && beat_gate(difficulty, beat_idx);
  assign pop     = !fifo_empty && spawn.spawn_ready;
  assign push_ok = gen && (!fifo_full || pop);

  // Lane choice: after MAX_REPEAT hits in one lane, move to the next lane over.
  assign cand      = random_col[1:0];
  assign same_lane = have_last && (cand == last_col);
  assign capped    = same_lane && (repeat_cnt == REP_MAX);

  always_comb begin
    pick_col = cand;
    pick_rep = RW'(1);
    if (capped)         pick_col = last_col + 2'd1;
    else if (same_lane) pick_rep = repeat_cnt + RW'(1);
  end

  // Song counters, repeat tracker and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      notes_spawned <= '0;
      overflow      <= 1'b0;
      beat_idx      <= 2'd0;
      have_last     <= 1'b0;
      last_col      <= '0;
      repeat_cnt    <= '0;
    end else if (song_start) begin
      notes_spawned <= '0;
      overflow      <= 1'b0;
      beat_idx      <= 2'd0;
      have_last     <= 1'b0;
      repeat_cnt    <= '0;
    end else begin
      if (gen_en && beat_tick) beat_idx <= beat_idx + 2'd1;
      if (push_ok) begin
        notes_spawned <= notes_spawned + 1'b1;
        last_col      <= pick_col;
        have_last     <= 1'b1;
        repeat_cnt    <= pick_rep;
      end else if (gen) begin
        overflow <= 1'b1;
      end
    end
  end

  note_spawner_fifo #(.DEPTH(FIFO_DEPTH), .W(LANE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop),
    .din   (pick_col),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign spawn.spawn_valid = !fifo_empty;
  assign spawn.spawn_col   = fifo_head;
  assign spawn.spawn_mask  = fifo_empty ? '0 : lane_onehot(fifo_head);
  assign fsm_state         = state;
endmodule
